// File: rtl/l_stf_gen.sv
// l_stf_gen: replays the 16-entry L-STF ROM NUM_REP times as a registered
// valid/ready sample stream, optionally halving the very first sample.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; rom_addr parked at 0
// ST_RUN  | sample_out/sample_valid presented, advancing on each handshake
// ST_DONE | one-cycle done pulse after the final handshake
module l_stf_gen #(
  parameter int unsigned NUM_REP   = 10,
  parameter bit          WINDOW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [3:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_REP = 4'(NUM_REP - 1);

  state_t      state_q, state_d;
  logic [3:0]  addr_cnt_q, addr_cnt_d;
  logic [3:0]  rep_cnt_q, rep_cnt_d;
  logic [31:0] sample_q, sample_d;
  logic        valid_q, valid_d;

  // Per-component arithmetic shift right by one (rounds toward -inf).
  function automatic logic [31:0] halve_iq(input logic [31:0] s);
    logic signed [15:0] i_s;
    logic signed [15:0] q_s;
    i_s = s[31:16];
    q_s = s[15:0];
    return {i_s >>> 1, q_s >>> 1};
  endfunction

  // State, counters and the output sample register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= 4'd0;
      rep_cnt_q  <= 4'd0;
      sample_q   <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic. addr_cnt always points one ahead of the presented
  // sample, so addr_cnt == 0 at a handshake means address 15 was accepted.
  // rep_cnt is the period of the presented sample and advances only once
  // that period's address-15 sample has been taken.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    sample_d   = sample_q;
    valid_d    = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sample_d   = WINDOW_EN ? halve_iq(rom_dout) : rom_dout;
          valid_d    = 1'b1;
          addr_cnt_d = 4'd1;
          rep_cnt_d  = 4'd0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (valid_q && sample_ready) begin
          if ((addr_cnt_q == 4'd0) && (rep_cnt_q == LAST_REP)) begin
            valid_d   = 1'b0;
            rep_cnt_d = 4'd0;
            state_d   = ST_DONE;
          end else begin
            sample_d   = rom_dout;
            addr_cnt_d = addr_cnt_q + 4'd1;
            if (addr_cnt_q == 4'd0) begin
              rep_cnt_d = rep_cnt_q + 4'd1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_addr     = addr_cnt_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_l_stf_gen.sv
// tb_l_stf_gen: three sequencer instances (default, no window, single period)
// driven with randomized backpressure and start noise, checked against an
// index-based model of the expected stream.
module tb_l_stf_gen;

  logic        clk;
  logic        rstn;
  logic        start_s [3];
  logic        ready_s [3];
  logic [3:0]  addr_s  [3];
  logic [31:0] dout_s  [3];
  logic [31:0] so_s    [3];
  logic        vld_s   [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [31:0] rom     [16];

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar k = 0; k < 3; k++) begin : g_rom
    assign dout_s[k] = rom[addr_s[k]];
  end

  l_stf_gen #(.NUM_REP(10), .WINDOW_EN(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .start(start_s[0]), .rom_addr(addr_s[0]),
    .rom_dout(dout_s[0]), .sample_out(so_s[0]), .sample_valid(vld_s[0]),
    .sample_ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  l_stf_gen #(.NUM_REP(10), .WINDOW_EN(1'b0)) u_nowin (
    .clk(clk), .rstn(rstn), .start(start_s[1]), .rom_addr(addr_s[1]),
    .rom_dout(dout_s[1]), .sample_out(so_s[1]), .sample_valid(vld_s[1]),
    .sample_ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  l_stf_gen #(.NUM_REP(1), .WINDOW_EN(1'b1)) u_rep1 (
    .clk(clk), .rstn(rstn), .start(start_s[2]), .rom_addr(addr_s[2]),
    .rom_dout(dout_s[2]), .sample_out(so_s[2]), .sample_valid(vld_s[2]),
    .sample_ready(ready_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Floor of x/2 computed with integer arithmetic.
  function automatic int floor_half(input int x);
    return (x >= 0) ? (x / 2) : -((-x + 1) / 2);
  endfunction

  // Expected sample for global stream index i.
  function automatic logic [31:0] exp_sample(input int i, input bit win);
    logic [31:0] v;
    int re, im, hre, him;
    v = rom[i % 16];
    if (win && i == 0) begin
      re  = int'($signed(v[31:16]));
      im  = int'($signed(v[15:0]));
      hre = floor_half(re);
      him = floor_half(im);
      v   = {hre[15:0], him[15:0]};
    end
    return v;
  endfunction

  task automatic check_reset(input int idx);
    chk("rst_addr",  32'(addr_s[idx]), 32'd0);
    chk("rst_sample", so_s[idx], 32'd0);
    chk("rst_valid", 32'(vld_s[idx]), 32'd0);
    chk("rst_busy",  32'(busy_s[idx]), 32'd0);
    chk("rst_done",  32'(done_s[idx]), 32'd0);
  endtask

  // Called near a negedge while the instance is idle; start is sampled on
  // the following posedge.
  task automatic pulse_start(input int idx);
    start_s[idx] = 1'b1;
    @(posedge clk);
  endtask

  // Follows one burst from just after the start edge. abort_at >= 0 returns
  // right after that many handshakes without waiting for completion.
  task automatic stream(input int idx, input int n, input bit win, input bit rnd,
                        input bit noise, input int abort_at);
    int cnt = 0;
    int cyc = 0;
    bit rdy;
    while (cnt < n && cyc < n * 4 + 20) begin
      @(negedge clk);
      chk("valid",  32'(vld_s[idx]), 32'd1);
      chk("sample", so_s[idx], exp_sample(cnt, win));
      chk("rom_addr", 32'(addr_s[idx]), 32'((cnt + 1) % 16));
      chk("busy",   32'(busy_s[idx]), 32'd1);
      chk("done_early", 32'(done_s[idx]), 32'd0);
      rdy = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      ready_s[idx] = rdy;
      start_s[idx] = noise && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      cyc++;
      if (rdy) cnt++;
      if (abort_at >= 0 && cnt == abort_at) return;
    end
    if (cnt < n) chk("timeout_handshakes", cnt, n);
    @(negedge clk);
    start_s[idx] = noise;
    ready_s[idx] = bit'($urandom_range(0, 1));
    chk("end_valid", 32'(vld_s[idx]), 32'd0);
    chk("end_done",  32'(done_s[idx]), 32'd1);
    chk("end_busy",  32'(busy_s[idx]), 32'd1);
    if (!rnd) chk("edges_to_done", cyc, n);
    @(negedge clk);
    start_s[idx] = 1'b0;
    chk("idle_done",  32'(done_s[idx]), 32'd0);
    chk("idle_busy",  32'(busy_s[idx]), 32'd0);
    chk("idle_valid", 32'(vld_s[idx]), 32'd0);
    chk("idle_addr",  32'(addr_s[idx]), 32'd0);
  endtask

  initial begin
    rom[0]  = 32'hfd0e_fd0e;  rom[1]  = 32'hfc27_0198;
    rom[2]  = 32'h0ab3_f6a1;  rom[3]  = 32'h1234_8000;
    rom[4]  = 32'h7fff_0001;  rom[5]  = 32'h0001_ffff;
    rom[6]  = 32'hffff_8001;  rom[7]  = 32'h4000_c000;
    rom[8]  = 32'h02f2_02f2;  rom[9]  = 32'h0d59_fa11;
    rom[10] = 32'hf3c5_0e3b;  rom[11] = 32'h0066_1357;
    rom[12] = 32'h0000_0bcd;  rom[13] = 32'hffe0_1357;
    rom[14] = 32'hf3c5_fc00;  rom[15] = 32'h0198_fc27;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      ready_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset(k);
    rstn = 1'b1;

    // Windowed burst, ready held high.
    pulse_start(0);
    stream(0, 160, 1'b1, 1'b0, 1'b0, -1);

    // No window: every sample is ROM[i mod 16].
    pulse_start(1);
    stream(1, 160, 1'b0, 1'b0, 1'b0, -1);

    // Random backpressure.
    pulse_start(0);
    stream(0, 160, 1'b1, 1'b1, 1'b0, -1);

    // Start noise during RUN and in the done cycle, then restart on first idle.
    pulse_start(0);
    stream(0, 160, 1'b1, 1'b0, 1'b1, -1);
    pulse_start(0);
    stream(0, 160, 1'b1, 1'b1, 1'b0, -1);

    // Reset after the 50th handshake, then replay from sample 0.
    pulse_start(0);
    stream(0, 160, 1'b1, 1'b1, 1'b0, 50);
    #2 rstn = 1'b0;
    #1 check_reset(0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done_s[0]), 32'd0);
      chk("abort_idle", 32'(busy_s[0]), 32'd0);
    end
    rstn = 1'b1;
    pulse_start(0);
    stream(0, 160, 1'b1, 1'b1, 1'b0, -1);

    // Single period.
    pulse_start(2);
    stream(2, 16, 1'b1, 1'b0, 1'b0, -1);
    pulse_start(2);
    stream(2, 16, 1'b1, 1'b1, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/l_stf_gen.md
# l_stf_gen

Sequencer directly downstream of the L-STF sample ROM in the OFDM TX path. On a start pulse it reads the 16-entry ROM ten times, for 160 samples (8 µs at 20 MSPS), and streams the samples out over a valid/ready handshake. It optionally halves the first sample to apply the standard preamble window. It sits between the TX control FSM and the preamble/data mux that feeds the DAC interface.

## Interface
- NUM_REP, 10: number of 16-sample periods emitted (legal range 1..15).
- WINDOW_EN, 1: when 1, sample index 0 is halved per component.
- clk, input, 1: sole clock.
- rstn, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request; honoured only in IDLE.
- rom_addr, output, 4: address to the L-STF ROM.
- rom_dout, input, 32: combinational ROM data; [31:16] = I, [15:0] = Q, signed 16-bit.
- sample_out, output, 32: registered sample; same packing as rom_dout.
- sample_valid, output, 1: sample_out holds a valid sample.
- sample_ready, input, 1: consumer accepts sample_out.
- busy, output, 1: high whenever the state is not IDLE.
- done, output, 1: one-cycle pulse after the last sample is accepted.

## Operation
- States: IDLE, RUN, DONE.
- Counters: 4-bit addr_cnt drives rom_addr directly; 4-bit rep_cnt counts 0..NUM_REP-1.
- IDLE:
  - rom_addr = 0.
  - On start, load sample_out from rom_dout (addr 0), with window applied if WINDOW_EN.
  - Set sample_valid = 1, addr_cnt = 1, rep_cnt = 0, then go to RUN.
- RUN, when sample_valid && sample_ready:
  - If the accepted sample is the last one (rep_cnt == NUM_REP-1 and accepted addr == 15), clear sample_valid, pulse done, and go to DONE.
  - Otherwise load sample_out from rom_dout (current rom_addr) and increment addr_cnt.
  - When addr_cnt wraps 15 -> 0, increment rep_cnt.
- RUN, without a handshake: sample_out, sample_valid, rom_addr and the counters all hold. sample_valid never drops before acceptance.
- DONE: lasts one cycle, then IDLE. done is high only during this cycle.
- Window rule: I and Q are each arithmetic-shifted right by 1 (sign-preserving, truncated toward -inf). It applies only to global sample index 0, never to index 16, 32, and so on.
- No other arithmetic is performed; ROM data passes through bit-exact.
- start in RUN or DONE is ignored, with no restart or queueing.
- start asserted in the same cycle done is high: ignored, because the state is DONE. A new start is accepted from the following IDLE cycle.

## Timing
- Reset values:
  - rom_addr = 0, sample_out = 0, sample_valid = 0, busy = 0, done = 0.
  - State IDLE, both counters 0.
- Reset asserted mid-RUN: immediately forces the reset values and abandons the burst; no done pulse.
- Latency: start sampled on edge E0 gives sample_valid = 1 and sample 0 on sample_out after E0.
- Throughput: one sample per cycle while sample_ready = 1. With ready held high:
  - Handshakes occur on edges E1..E160.
  - After E160, sample_valid = 0 and done = 1.
  - After E161, done = 0, busy = 0, and start is accepted again.
- Backpressure: each cycle with sample_ready = 0 adds exactly one cycle. Total burst = 160 + number of stall cycles.
- rom_addr is registered. The combinational ROM path rom_addr -> rom_dout -> sample_out register is one cycle.

## Test plan
- WINDOW_EN = 1, ready held high, single start:
  - Sample 0 = 0xfe87_fe87, sample 1 = 0xfc27_0198, sample 16 = 0xfd0e_fd0e, sample 159 = 0x0198_fc27.
  - Exactly 160 handshakes; done for 1 cycle after E160.
- WINDOW_EN = 0:
  - Sample 0 = 0xfd0e_fd0e; all 160 samples equal ROM[i mod 16].
- Random sample_ready (50 %):
  - sample_out and sample_valid stay stable during stalls; the sequence is identical to the previous test; done follows the 160th handshake.
- start pulsed during RUN and in the done cycle:
  - Ignored; still 160 samples.
  - A start on the first IDLE cycle launches a second burst starting at 0xfe87_fe87.
- rstn dropped after the 50th handshake:
  - Outputs go to reset values asynchronously; no done.
  - A fresh start replays from sample 0.
- NUM_REP = 1:
  - 16 samples, last = 0x0198_fc27; done after E16.
